// File: rtl/pwm_duty_ctrl.sv
// Programmable PWM generator with glitch-free, handshake-driven period/duty reconfiguration.
// Define PWM_PERIOD_CNT_EN to add the saturating completed-period counter output 'periods'.
module pwm_duty_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             pwm_out,
  output logic [CNT_W-1:0] count,
  output logic             period_done,
  output logic             busy
`ifdef PWM_PERIOD_CNT_EN
  ,
  output logic [15:0]      periods
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] per_act, high_act, per_pend, high_pend;
  logic [CNT_W-1:0] count_nxt, per_nxt, high_nxt;
  logic             pend_vld, pend_nxt;
  logic             boundary, accept, apply;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    boundary  = (state != IDLE) && (count == per_act);
    accept    = cfg_valid && !pend_vld;
    // pend_vld is only ever set by an earlier edge, so a boundary-cycle acceptance waits a period
    apply     = pend_vld && ((state == IDLE) || boundary);
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE: begin
        count_nxt = '0;
        if (en) state_nxt = RUN;
      end
      RUN: begin
        count_nxt = boundary ? '0 : count + ONE;
        if (!en) state_nxt = DRAIN;
      end
      DRAIN: begin
        count_nxt = boundary ? '0 : count + ONE;
        if (en)            state_nxt = RUN;
        else if (boundary) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
    if (state_nxt == IDLE) count_nxt = '0;
    per_nxt  = apply ? per_pend  : per_act;
    high_nxt = apply ? high_pend : high_act;
    pend_nxt = accept || (pend_vld && !apply);
  end

  // Outputs are registered from next-state values so they line up with state/count each cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      per_act     <= CNT_W'(9);
      high_act    <= CNT_W'(4);
      pend_vld    <= 1'b0;
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
      busy        <= 1'b0;
      cfg_ready   <= 1'b1;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      per_act     <= per_nxt;
      high_act    <= high_nxt;
      pend_vld    <= pend_nxt;
      pwm_out     <= (state_nxt != IDLE) && (count_nxt < high_nxt);
      period_done <= (state_nxt != IDLE) && (count_nxt == per_nxt);
      busy        <= (state_nxt != IDLE);
      cfg_ready   <= !pend_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      per_pend  <= cfg_period;
      high_pend <= cfg_high;
    end
  end

`ifdef PWM_PERIOD_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                  periods <= '0;
    else if (state == IDLE && state_nxt == RUN) periods <= '0;
    else if (boundary)                        periods <= sat_inc(periods);
  end
`endif

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Scoreboard bench for pwm_duty_ctrl: directed stimulus pushes cycle-tagged expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_pwm_duty_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, cfg_valid, cfg_ready;
  logic [7:0] cfg_period, cfg_high, count;
  logic       pwm_out, period_done, busy;
`ifdef PWM_PERIOD_CNT_EN
  logic [15:0] periods;
`endif

  pwm_duty_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .pwm_out(pwm_out), .count(count),
    .period_done(period_done), .busy(busy)
`ifdef PWM_PERIOD_CNT_EN
    , .periods(periods)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       pwm;
    logic [7:0] cnt;
    logic       pd;
    logic       bsy;
    logic       rdy;
    int         pc;
  } exp_t;

  exp_t sb[$];
  exp_t mx;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mx = sb.pop_front();
      total++;
      if ({pwm_out, count, period_done, busy, cfg_ready} !== {mx.pwm, mx.cnt, mx.pd, mx.bsy, mx.rdy})
        $display("FAIL outputs cyc=%0d got pwm=%b count=%0d done=%b busy=%b rdy=%b want pwm=%b count=%0d done=%b busy=%b rdy=%b",
                 cyc, pwm_out, count, period_done, busy, cfg_ready, mx.pwm, mx.cnt, mx.pd, mx.bsy, mx.rdy);
      else
        passed++;
`ifdef PWM_PERIOD_CNT_EN
      if (mx.pc >= 0) begin
        total++;
        if (periods !== 16'(mx.pc))
          $display("FAIL periods cyc=%0d got %0d want %0d", cyc, periods, mx.pc);
        else
          passed++;
      end
`endif
    end
  end

  function automatic exp_t mk(input logic p, input logic [7:0] c, input logic d, input logic b,
                              input logic r, input int pc);
    exp_t x;
    x.cyc = 0; x.pwm = p; x.cnt = c; x.pd = d; x.bsy = b; x.rdy = r; x.pc = pc;
    return x;
  endfunction

  task automatic step(input logic r, input logic e, input logic cv, input logic [7:0] cp,
                      input logic [7:0] ch, input exp_t x);
    rst = r; en = e; cfg_valid = cv; cfg_period = cp; cfg_high = ch;
    x.cyc = cyc + 1;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int pc);
    step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, pc));
  endtask

  // Steady waveform: count walks (c0+i) mod (per+1); pbase<0 leaves periods unchecked
  task automatic periodic(input int n, input int per, input int hi, input int c0,
                          input logic rdy, input logic e, input int pbase);
    for (int i = 0; i < n; i++) begin
      int c;
      c = (c0 + i) % (per + 1);
      step(1'b0, e, 1'b0, 8'd0, 8'd0,
           mk(c < hi, 8'(c), c == per, 1'b1, rdy, (pbase < 0) ? -1 : pbase + (c0 + i) / (per + 1)));
    end
  endtask

  task automatic offer(input logic [7:0] cp, input logic [7:0] ch, input exp_t x);
    step(1'b0, 1'b1, 1'b1, cp, ch, x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d pending=%0d want stimulus complete", cyc, sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_high = '0;
    // Reset state, then idle with en low
    step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 0));
    step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 0));
    idle(0);
    // Default 40 % waveform
    periodic(30, 9, 4, 0, 1'b1, 1'b1, 0);
    // Reconfigure to 5-cycle period, 1 high, offered at count 3
    periodic(4, 9, 4, 0, 1'b1, 1'b1, -1);
    offer(8'd4, 8'd1, mk(1'b0, 8'd4, 1'b0, 1'b1, 1'b0, -1));
    periodic(5, 9, 4, 5, 1'b0, 1'b1, -1);
    periodic(10, 4, 1, 0, 1'b1, 1'b1, -1);
    // Offer on a boundary cycle: waits one full period, then high=0
    offer(8'd9, 8'd0, mk(1'b1, 8'd0, 1'b0, 1'b1, 1'b0, -1));
    periodic(4, 4, 1, 1, 1'b0, 1'b1, -1);
    periodic(13, 9, 0, 0, 1'b1, 1'b1, -1);
    // high > period gives constant high
    offer(8'd9, 8'd12, mk(1'b0, 8'd3, 1'b0, 1'b1, 1'b0, -1));
    periodic(6, 9, 0, 4, 1'b0, 1'b1, -1);
    periodic(13, 9, 12, 0, 1'b1, 1'b1, -1);
    offer(8'd9, 8'd4, mk(1'b1, 8'd3, 1'b0, 1'b1, 1'b0, -1));
    periodic(6, 9, 12, 4, 1'b0, 1'b1, -1);
    // Drain: en drops at count 2, period completes, then idle
    periodic(3, 9, 4, 0, 1'b1, 1'b1, -1);
    periodic(7, 9, 4, 3, 1'b1, 1'b0, -1);
    idle(-1);
    idle(-1);
    // Drain interrupted by en at count 5: no gap
    periodic(3, 9, 4, 0, 1'b1, 1'b1, -1);
    periodic(3, 9, 4, 3, 1'b1, 1'b0, -1);
    periodic(8, 9, 4, 6, 1'b1, 1'b1, -1);
    // Reset at count 6 with a pending config discards it
    periodic(2, 9, 4, 4, 1'b1, 1'b1, -1);
    offer(8'd4, 8'd1, mk(1'b0, 8'd6, 1'b0, 1'b1, 1'b0, -1));
    step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, mk(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 0));
    idle(0);
    periodic(31, 9, 4, 0, 1'b1, 1'b1, 0);
    // Stop, then restart clears the period counter
    periodic(9, 9, 4, 1, 1'b1, 1'b0, -1);
    idle(4);
    periodic(3, 9, 4, 0, 1'b1, 1'b1, 0);
    // One-cycle period: period_done held high, then drain of a single cycle
    offer(8'd0, 8'd1, mk(1'b1, 8'd3, 1'b0, 1'b1, 1'b0, -1));
    periodic(6, 9, 4, 4, 1'b0, 1'b1, -1);
    periodic(5, 0, 1, 0, 1'b1, 1'b1, -1);
    periodic(1, 0, 1, 0, 1'b1, 1'b0, -1);
    idle(-1);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0)
      $display("FAIL drain_queue got %0d entries left want 0", sb.size());
    else
      passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
